i2c_reg_sequencer: RTL and testbench



---
 rtl/i2c_reg_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: turns one register write/read command into the byte-level handshakes of i2c_controller.
// Latency: bound by I2C bus time; rsp_valid pulses one cycle after the controller returns to idle (or on abort).
// Backpressure: cmd_ready is high only in IDLE; cmd_valid while busy is ignored. Optional watchdog: define SEQ_TIMEOUT_EN.
module i2c_reg_sequencer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_reg,
    input  logic [7:0]  cmd_wdata,
    input  logic [1:0]  cmd_len,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_data,
    output logic        i2c_enable,
    output logic        i2c_rw,
    input  logic        i2c_ready,
    input  logic        i2c_write_done,
    input  logic        i2c_data_rdy,
    input  logic [7:0]  i2c_rdata
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_LAUNCH,
        S_REG,
        S_WDAT,
        S_RSTRT,
        S_RDAT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;

    state_t      state;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    logic [1:0]  len_q;
    logic [1:0]  idx;
    logic        rstrt_seen;
    logic        wdog_hit;

    // A watchdog limit of zero would fire before the controller could ever respond.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef SEQ_TIMEOUT_EN
    logic [31:0] wdog;
    logic        step;
    logic        counting;

    assign counting = (state != S_IDLE) && (state != S_DONE);

    // Step: the FSM leaves its current state this cycle (mirrors the transition conditions below).
    always_comb begin
        step = 1'b0;
        case (state)
            S_ARM, S_DRAIN: step = i2c_ready;
            S_LAUNCH:       step = !i2c_ready;
            S_REG, S_WDAT:  step = i2c_write_done || i2c_ready;
            S_RSTRT:        step = rstrt_seen && !i2c_ready;
            S_RDAT:         step = i2c_data_rdy || i2c_ready;
            default:        step = 1'b0;
        endcase
    end

    assign wdog_hit = counting && !step && !i2c_write_done && !i2c_data_rdy
                      && (wdog == 32'(TIMEOUT_CYCLES));

    // Watchdog: counts busy cycles, restarts on any controller progress or state change.
    always_ff @(posedge clk) begin
        if (rst || !counting || step || i2c_write_done || i2c_data_rdy) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 32'd1;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // Main sequencer: walks the controller through address, register byte, then write data or repeated-start read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= ERR_OK;
            i2c_enable <= 1'b0;
            i2c_rw     <= 1'b0;
            i2c_addr   <= '0;
            i2c_data   <= '0;
            idx        <= '0;
            rstrt_seen <= 1'b0;
            rw_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            len_q      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        rw_q      <= cmd_rw;
                        dev_q     <= cmd_dev;
                        reg_q     <= cmd_reg;
                        wdata_q   <= cmd_wdata;
                        len_q     <= cmd_len;
                        rsp_data  <= '0;
                        rsp_err   <= ERR_OK;
                        idx       <= '0;
                        cmd_ready <= 1'b0;
                        state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (i2c_ready) begin
                        i2c_addr   <= dev_q;
                        i2c_rw     <= 1'b0;
                        i2c_data   <= reg_q;
                        i2c_enable <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (!i2c_ready) begin
                        state <= S_REG;
                    end
                end
                S_REG: begin
                    // A pulse coinciding with ready still counts as a transferred byte.
                    if (i2c_write_done) begin
                        if (rw_q) begin
                            i2c_rw     <= 1'b1;
                            rstrt_seen <= 1'b0;
                            state      <= S_RSTRT;
                        end else begin
                            i2c_data <= wdata_q;
                            state    <= S_WDAT;
                        end
                    end else if (i2c_ready) begin
                        i2c_enable <= 1'b0;
                        rsp_err    <= ERR_NACK;
                        rsp_valid  <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_WDAT: begin
                    if (i2c_write_done) begin
                        i2c_enable <= 1'b0;
                        state      <= S_DRAIN;
                    end else if (i2c_ready) begin
                        i2c_enable <= 1'b0;
                        rsp_err    <= ERR_NACK;
                        rsp_valid  <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_RSTRT: begin
                    // Ready high here is the controller passing through idle for the repeated start.
                    if (i2c_ready) begin
                        rstrt_seen <= 1'b1;
                    end else if (rstrt_seen) begin
                        state <= S_RDAT;
                    end
                end
                S_RDAT: begin
                    if (i2c_data_rdy) begin
                        rsp_data[{idx, 3'b000} +: 8] <= i2c_rdata;
                        idx <= idx + 2'd1;
                        if (idx == len_q) begin
                            i2c_enable <= 1'b0;
                            state      <= S_DRAIN;
                        end
                    end else if (i2c_ready) begin
                        i2c_enable <= 1'b0;
                        rsp_err    <= ERR_NACK;
                        rsp_valid  <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (i2c_ready) begin
                        rsp_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    i2c_rw    <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    i2c_enable <= 1'b0;
                    cmd_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
            // Watchdog abort overrides whatever the current state decided this cycle.
            if (wdog_hit) begin
                i2c_enable <= 1'b0;
                rsp_err    <= ERR_TO;
                rsp_valid  <= 1'b1;
                state      <= S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: drives register commands against a behavioural i2c_controller model.
// Expected responses are queued when a command is issued and compared when rsp_valid pulses.
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;

    localparam int TO  = 100;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic [7:0]  cmd_wdata;
    logic [1:0]  cmd_len;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_data;
    logic        i2c_enable;
    logic        i2c_rw;
    logic        i2c_ready;
    logic        i2c_write_done;
    logic        i2c_data_rdy;
    logic [7:0]  i2c_rdata;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .i2c_addr(i2c_addr), .i2c_data(i2c_data), .i2c_enable(i2c_enable), .i2c_rw(i2c_rw),
        .i2c_ready(i2c_ready), .i2c_write_done(i2c_write_done),
        .i2c_data_rdy(i2c_data_rdy), .i2c_rdata(i2c_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bookkeeping
    int          cyc = 0;
    int          acc = 0;
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    logic [33:0] exp_q[$];
    logic [33:0] exp_e;

    always @(posedge clk) cyc++;

    always @(posedge clk) if (rst === 1'b0 && cmd_valid && cmd_ready) acc++;

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && rsp_valid === 1'b1) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                chk("rsp_data", rsp_data, exp_e[31:0]);
                chk("rsp_err", {30'd0, rsp_err}, {30'd0, exp_e[33:32]});
                chk("rsp_enable_low", {31'd0, i2c_enable}, 32'd0);
            end
        end
    end

    // Behavioural controller model
    typedef enum {M_IDLE, M_ADDR, M_WBYTE, M_WGAP, M_RSTART, M_RBYTE, M_RGAP, M_STOP, M_STUCK} mstate_t;
    mstate_t    ms;
    int         mcnt;
    int         mode;          // 0 ack, 1 address nack, 2 stuck busy
    logic [7:0] rbytes[4];
    int         ri;
    logic [7:0] wlog[$];
    logic [6:0] alog[$];
    logic       rwlog[$];
    int         rs_cnt, wd_cnt, dr_cnt, drop_cyc;
    bit         nack_fired;

    task automatic clear_logs();
        wlog.delete(); alog.delete(); rwlog.delete();
        rs_cnt = 0; wd_cnt = 0; dr_cnt = 0; ri = 0; nack_fired = 0;
    endtask

    initial begin
        ms = M_IDLE; mcnt = 0; mode = 0;
        i2c_ready = 1'b1; i2c_write_done = 1'b0; i2c_data_rdy = 1'b0; i2c_rdata = '0;
        forever begin
            @(posedge clk); #1;
            i2c_write_done = 1'b0;
            i2c_data_rdy   = 1'b0;
            if (rst) begin
                ms = M_IDLE; i2c_ready = 1'b1; mcnt = 0;
            end else begin
                case (ms)
                    M_IDLE: if (i2c_enable) begin
                        i2c_ready = 1'b0; mcnt = 0; drop_cyc = cyc;
                        ms = (mode == 2) ? M_STUCK : M_ADDR;
                    end
                    M_ADDR: if (++mcnt == DIV) begin
                        mcnt = 0; alog.push_back(i2c_addr); rwlog.push_back(i2c_rw);
                        if (mode == 1) begin i2c_ready = 1'b1; nack_fired = 1; ms = M_IDLE; end
                        else ms = i2c_rw ? M_RBYTE : M_WBYTE;
                    end
                    M_WBYTE: if (++mcnt == DIV) begin
                        mcnt = 0; i2c_write_done = 1'b1; wd_cnt++; wlog.push_back(i2c_data); ms = M_WGAP;
                    end
                    M_WGAP: if (++mcnt == DIV) begin
                        mcnt = 0;
                        if (!i2c_enable) ms = M_STOP;
                        else if (i2c_rw) begin i2c_ready = 1'b1; rs_cnt++; ms = M_RSTART; end
                        else ms = M_WBYTE;
                    end
                    M_RSTART: if (++mcnt == 2) begin mcnt = 0; i2c_ready = 1'b0; ms = M_ADDR; end
                    M_RBYTE: if (++mcnt == DIV) begin
                        mcnt = 0; i2c_data_rdy = 1'b1; i2c_rdata = rbytes[ri % 4]; ri++; dr_cnt++; ms = M_RGAP;
                    end
                    M_RGAP: if (++mcnt == DIV) begin mcnt = 0; ms = i2c_enable ? M_RBYTE : M_STOP; end
                    M_STOP: if (++mcnt == DIV) begin mcnt = 0; i2c_ready = 1'b1; ms = M_IDLE; end
                    default: ;
                endcase
            end
        end
    end

    task automatic send_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd, input logic [1:0] len);
        int a0;
        @(negedge clk);
        cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_len = len;
        a0 = acc;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && acc == a0; i++) @(negedge clk);
        cmd_valid = 1'b0;
        chk("accept", 32'(acc - a0), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        @(negedge clk);
        for (int i = 0; i < budget && rsp_valid !== 1'b1; i++) @(negedge clk);
        chk(tag, {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int a0, snap;
        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = '0;
        cmd_reg = '0; cmd_wdata = '0; cmd_len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
        chk("rst_enable", {31'd0, i2c_enable}, 32'd0);
        chk("rst_rw", {31'd0, i2c_rw}, 32'd0);
        chk("rst_addr", {25'd0, i2c_addr}, 32'd0);
        chk("rst_data", {24'd0, i2c_data}, 32'd0);
        rst = 1'b0;

        // Register write
        clear_logs();
        exp_q.push_back({2'b00, 32'h0});
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 2'd0);
        wait_rsp("wr_rsp", 2000);
        chk("wr_pulses", wd_cnt, 2);
        chk("wr_byte0", {24'd0, wlog[0]}, 32'h10);
        chk("wr_byte1", {24'd0, wlog[1]}, 32'hA5);
        chk("wr_addr", {25'd0, alog[0]}, 32'h50);
        @(negedge clk);
        chk("wr_ready_after", {31'd0, cmd_ready}, 32'd1);

        // Four-byte read with repeated start
        clear_logs();
        rbytes[0] = 8'h11; rbytes[1] = 8'h22; rbytes[2] = 8'h33; rbytes[3] = 8'h44;
        exp_q.push_back({2'b00, 32'h44332211});
        send_cmd(1'b1, 7'h68, 8'h3B, 8'hFF, 2'd3);
        wait_rsp("rd4_rsp", 3000);
        chk("rd4_rstart", rs_cnt, 1);
        chk("rd4_rw_first", {31'd0, rwlog[0]}, 32'd0);
        chk("rd4_rw_second", {31'd0, rwlog[1]}, 32'd1);
        chk("rd4_reg_byte", {24'd0, wlog[0]}, 32'h3B);
        chk("rd4_addr2", {25'd0, alog[1]}, 32'h68);
        chk("rd4_bytes", dr_cnt, 4);

        // One-byte read: upper bytes must be zero after the previous 4-byte result
        clear_logs();
        rbytes[0] = 8'h5A;
        exp_q.push_back({2'b00, 32'h0000005A});
        send_cmd(1'b1, 7'h1D, 8'h07, 8'h00, 2'd0);
        wait_rsp("rd1_rsp", 3000);
        chk("rd1_bytes", dr_cnt, 1);

        // Address NACK
        clear_logs();
        mode = 1;
        exp_q.push_back({2'b01, 32'h0});
        send_cmd(1'b0, 7'h22, 8'h01, 8'h77, 2'd0);
        for (int i = 0; i < 500 && !nack_fired; i++) @(negedge clk);
        chk("nack_seen", {31'd0, nack_fired}, 32'd1);
        @(negedge clk);
        chk("nack_enable", {31'd0, i2c_enable}, 32'd0);
        chk("nack_rsp_now", {31'd0, rsp_valid}, 32'd1);
        chk("nack_no_wd", wd_cnt, 0);
        mode = 0;
        repeat (3) @(negedge clk);

        // cmd_valid held high across two transactions
        clear_logs();
        exp_q.push_back({2'b00, 32'h0});
        exp_q.push_back({2'b00, 32'h0});
        @(negedge clk);
        cmd_rw = 1'b0; cmd_dev = 7'h50; cmd_reg = 8'h20; cmd_wdata = 8'h3C; cmd_len = 2'd0;
        a0 = acc;
        cmd_valid = 1'b1;
        wait_rsp("hold_rsp1", 2000);
        chk("hold_one_accept", 32'(acc - a0), 32'd1);
        wait_rsp("hold_rsp2", 2000);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("hold_two_accepts", 32'(acc - a0), 32'd2);
        chk("hold_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("hold_bytes", wd_cnt, 4);

        // Reset in the middle of a read
        clear_logs();
        rbytes[0] = 8'hA1; rbytes[1] = 8'hB2; rbytes[2] = 8'hC3; rbytes[3] = 8'hD4;
        send_cmd(1'b1, 7'h33, 8'h44, 8'h00, 2'd3);
        for (int i = 0; i < 2000 && ri < 2; i++) @(negedge clk);
        chk("mid_rd_progress", 32'(ri), 32'd2);
        snap = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_enable", {31'd0, i2c_enable}, 32'd0);
        chk("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mrst_rsp_data", rsp_data, 32'd0);
        chk("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("mrst_no_rsp", rsp_cnt, snap);

`ifdef SEQ_TIMEOUT_EN
        // Controller stuck busy: watchdog must abort with timeout status
        clear_logs();
        mode = 2;
        exp_q.push_back({2'b10, 32'h0});
        send_cmd(1'b0, 7'h44, 8'h55, 8'h66, 2'd0);
        wait_rsp("to_rsp", 1000);
        chk("to_latency_window", 32'((rsp_cyc - drop_cyc) >= TO && (rsp_cyc - drop_cyc) <= TO + 3), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
